// File: rtl/mem_access_stage.sv
// Memory-access stage plus MEM/WB pipeline register for the 64-bit RISC-V core.
// Doubleword loads and stores run against a multi-cycle data memory over a
// req/ack handshake. The upstream pipeline is held while an access is in
// flight, and a watchdog aborts an access whose ack never arrives.
module mem_access_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] exmem_alu_result,
  input  logic [63:0] exmem_store_data,
  input  logic [63:0] exmem_branch_target,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_branch,
  input  logic        exmem_zero,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  input  logic        exmem_memtoreg,
  input  logic        exmem_regwrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic [63:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        pcsrc,
  output logic [63:0] branch_pc,
  output logic [4:0]  memwb_rd,
  output logic        memwb_regwrite,
  output logic        memwb_memtoreg,
  output logic [63:0] memwb_read_data,
  output logic [63:0] memwb_alu_result,
  output logic [63:0] wb_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   cap_q, cap_d;       // read data captured on ack
  logic          tmo_q, tmo_d;       // access ended by watchdog
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;
  logic [4:0]    wb_rd_q, wb_rd_d;
  logic          wb_rw_q, wb_rw_d;
  logic          wb_m2r_q, wb_m2r_d;
  logic [63:0]   wb_rdata_q, wb_rdata_d;
  logic [63:0]   wb_alu_q, wb_alu_d;

  logic memop_s;
  logic aligned_s;

  assign memop_s   = exmem_memread | exmem_memwrite;
  assign aligned_s = (exmem_alu_result[2:0] == 3'b000);

  // Next-state logic for the access FSM and the MEM/WB register contents.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cap_d      = cap_q;
    tmo_d      = tmo_q;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    // Bubble unless a branch below loads a real instruction.
    wb_rd_d    = 5'd0;
    wb_rw_d    = 1'b0;
    wb_m2r_d   = 1'b0;
    wb_rdata_d = 64'd0;
    wb_alu_d   = 64'd0;

    case (state_q)
      ST_IDLE: begin
        if (memop_s) begin
          if (aligned_s) begin
            state_d = ST_BUSY;
            req_d   = 1'b1;
            we_d    = exmem_memwrite;
            addr_d  = exmem_alu_result;
            wdata_d = exmem_store_data;
            cnt_d   = {CW{1'b0}};
            cap_d   = 64'd0;
            tmo_d   = 1'b0;
          end else begin
            // Misaligned: no bus access, instruction retires without a write.
            mis_d    = 1'b1;
            wb_rd_d  = exmem_rd;
            wb_m2r_d = exmem_memtoreg;
            wb_alu_d = exmem_alu_result;
          end
        end else begin
          wb_rd_d  = exmem_rd;
          wb_rw_d  = exmem_regwrite;
          wb_m2r_d = exmem_memtoreg;
          wb_alu_d = exmem_alu_result;
        end
      end
      ST_BUSY: begin
        if (dmem_ack && req_q) begin
          // Ack takes priority over a watchdog expiry in the same cycle.
          cap_d   = we_q ? 64'd0 : dmem_rdata;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_MAX) begin
          cap_d   = 64'd0;
          req_d   = 1'b0;
          berr_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        // EX/MEM is still frozen on the memory instruction here.
        wb_rd_d    = exmem_rd;
        wb_rw_d    = exmem_regwrite & ~tmo_q;
        wb_m2r_d   = exmem_memtoreg;
        wb_alu_d   = exmem_alu_result;
        wb_rdata_d = cap_q;
        cnt_d      = {CW{1'b0}};
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State, bus-side latches, error pulses and MEM/WB register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CW{1'b0}};
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      cap_q      <= 64'd0;
      tmo_q      <= 1'b0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_rw_q    <= 1'b0;
      wb_m2r_q   <= 1'b0;
      wb_rdata_q <= 64'd0;
      wb_alu_q   <= 64'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cap_q      <= cap_d;
      tmo_q      <= tmo_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_m2r_q   <= wb_m2r_d;
      wb_rdata_q <= wb_rdata_d;
      wb_alu_q   <= wb_alu_d;
    end
  end

  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign misalign_err     = mis_q;
  assign bus_err          = berr_q;
  assign memwb_rd         = wb_rd_q;
  assign memwb_regwrite   = wb_rw_q;
  assign memwb_memtoreg   = wb_m2r_q;
  assign memwb_read_data  = wb_rdata_q;
  assign memwb_alu_result = wb_alu_q;
  assign wb_data          = wb_m2r_q ? wb_rdata_q : wb_alu_q;

  assign stall     = ((state_q == ST_IDLE) & memop_s & aligned_s) | (state_q == ST_BUSY);
  assign pcsrc     = exmem_branch & exmem_zero & ~stall;
  assign branch_pc = exmem_branch_target;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stimulus pushes expected MEM/WB
// contents into a scoreboard; a monitor pops and compares each retirement.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] exmem_alu_result, exmem_store_data, exmem_branch_target;
  logic [4:0]  exmem_rd;
  logic        exmem_branch, exmem_zero, exmem_memread, exmem_memwrite;
  logic        exmem_memtoreg, exmem_regwrite;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        stall, pcsrc;
  logic [63:0] branch_pc;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite, memwb_memtoreg;
  logic [63:0] memwb_read_data, memwb_alu_result, wb_data;
  logic        misalign_err, bus_err;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data),
    .exmem_branch_target(exmem_branch_target), .exmem_rd(exmem_rd),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
    .exmem_memtoreg(exmem_memtoreg), .exmem_regwrite(exmem_regwrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .pcsrc(pcsrc), .branch_pc(branch_pc),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .memwb_memtoreg(memwb_memtoreg), .memwb_read_data(memwb_read_data),
    .memwb_alu_result(memwb_alu_result), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] wb;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   track = 1'b0;
  bit   pend  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one cycle after a tracked op is accepted (stall low), MEM/WB holds it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_underflow: got a retirement, expected none");
          end else begin
            e = sb.pop_front();
            if (e.chk_rd) check("sb_rd", 64'(memwb_rd), 64'(e.rd));
            check("sb_regwrite", 64'(memwb_regwrite), 64'(e.rw));
            check("sb_wb_data", wb_data, e.wb);
          end
        end
        pend = track && !stall;
      end
    end
  end

  task automatic set_op(input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd,
                        input logic mr, input logic mw, input logic m2r, input logic rw,
                        input logic br, input logic z, input logic [63:0] tgt);
    exmem_alu_result = alu; exmem_store_data = sd; exmem_rd = rd;
    exmem_memread = mr; exmem_memwrite = mw; exmem_memtoreg = m2r;
    exmem_regwrite = rw; exmem_branch = br; exmem_zero = z; exmem_branch_target = tgt;
  endtask

  task automatic nop();
    set_op(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    track = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic [63:0] wb, input bit crd);
    exp_t e;
    e.rd = rd; e.rw = rw; e.wb = wb; e.chk_rd = crd;
    sb.push_back(e);
  endtask

  // Runs one memory op from posedge+1; lat < 0 means no ack ever.
  task automatic do_mem(input logic [63:0] addr, input logic [63:0] wd, input logic mw,
                        input logic [4:0] rd, input logic m2r, input logic rw,
                        input int lat, input logic [63:0] rdata,
                        input int exp_stall, input int exp_req, input int exp_berr,
                        input logic exp_rw, input logic [63:0] exp_wb);
    int nstall = 0, nreq = 0, nberr = 0;
    bit done = 1'b0;
    set_op(addr, wd, rd, ~mw, mw, m2r, rw, 1'b0, 1'b0, 64'd0);
    track = 1'b1;
    push(rd, exp_rw, exp_wb, 1'b1);
    for (int c = 0; c < 100; c++) begin
      dmem_ack   = (c == lat);
      dmem_rdata = rdata;
      @(negedge clk);
      if (stall) nstall++;
      if (bus_err) nberr++;
      if (dmem_req) begin
        nreq++;
        check("bus_addr", dmem_addr, addr);
        check("bus_we", 64'(dmem_we), 64'(mw));
        if (mw) check("bus_wdata", dmem_wdata, wd);
      end
      done = !stall;
      @(posedge clk); #1;
      if (done) break;
    end
    dmem_ack = 1'b0;
    nop();
    check("access_completed", 64'(done), 64'd1);
    check("stall_cycles", 64'(nstall), 64'(exp_stall));
    check("req_cycles", 64'(nreq), 64'(exp_req));
    check("bus_err_pulses", 64'(nberr), 64'(exp_berr));
  endtask

  initial begin
    int guard;
    reset = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 64'd0;
    nop();
    #3;
    check("rst_req", 64'(dmem_req), 64'd0);
    check("rst_we", 64'(dmem_we), 64'd0);
    check("rst_addr", dmem_addr, 64'd0);
    check("rst_wdata", dmem_wdata, 64'd0);
    check("rst_regwrite", 64'(memwb_regwrite), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_errs", 64'({misalign_err, bus_err}), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an outstanding access.
    set_op(64'h80, 64'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    guard = 0;
    while (!dmem_req && guard < 10) begin @(negedge clk); guard++; end
    check("rstbusy_req_seen", 64'(dmem_req), 64'd1);
    @(negedge clk); #2;
    reset = 1'b0;
    nop();
    #1;
    check("rstbusy_req", 64'(dmem_req), 64'd0);
    check("rstbusy_addr", dmem_addr, 64'd0);
    check("rstbusy_stall", 64'(stall), 64'd0);
    check("rstbusy_memwb", {memwb_alu_result[58:0], memwb_rd}, 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_req", 64'(dmem_req), 64'd0);
    check("post_rst_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;

    // Load, ack in cycle 3: stall 4, req 3.
    do_mem(64'h100, 64'd0, 1'b0, 5'd5, 1'b1, 1'b1, 3, 64'hDEADBEEF_CAFEF00D,
           4, 3, 0, 1'b1, 64'hDEADBEEF_CAFEF00D);

    // Store, ack in cycle 1: stall 2, wb_data shows the address.
    do_mem(64'h208, 64'h1234, 1'b1, 5'd0, 1'b0, 1'b0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
           2, 1, 0, 1'b0, 64'h208);

    // ALU op then branch, back to back with no stall.
    set_op(64'h42, 64'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0);
    track = 1'b1;
    push(5'd3, 1'b1, 64'h42, 1'b1);
    @(negedge clk);
    check("alu_stall", 64'(stall), 64'd0);
    check("alu_pcsrc", 64'(pcsrc), 64'd0);
    @(posedge clk); #1;
    set_op(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h400);
    push(5'd0, 1'b0, 64'd0, 1'b1);
    @(negedge clk);
    check("br_stall", 64'(stall), 64'd0);
    check("br_pcsrc", 64'(pcsrc), 64'd1);
    check("br_pc", branch_pc, 64'h400);
    @(posedge clk); #1;
    nop();

    // Misaligned load: no access, single error pulse, no write-back.
    set_op(64'h103, 64'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
    track = 1'b1;
    push(5'd7, 1'b0, 64'd0, 1'b0);
    @(negedge clk);
    check("mis_stall", 64'(stall), 64'd0);
    check("mis_err_early", 64'(misalign_err), 64'd0);
    @(posedge clk); #1;
    nop();
    @(negedge clk);
    check("mis_err_pulse", 64'(misalign_err), 64'd1);
    check("mis_req", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mis_err_end", 64'(misalign_err), 64'd0);
    check("mis_req_later", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;

    // Stray ack while idle is ignored.
    dmem_ack = 1'b1;
    dmem_rdata = 64'h5555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_req", 64'(dmem_req), 64'd0);
    check("stray_ack_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;

    // Watchdog: no ack, req high exactly 4 cycles, bus_err, no write-back.
    do_mem(64'h300, 64'd0, 1'b0, 5'd11, 1'b1, 1'b1, -1, 64'h9999,
           5, 4, 1, 1'b0, 64'd0);
    @(negedge clk);
    check("tmo_bus_err_end", 64'(bus_err), 64'd0);
    check("tmo_resume_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;

    // Ack in the same cycle the watchdog count is reached: ack wins.
    do_mem(64'h318, 64'd0, 1'b0, 5'd12, 1'b1, 1'b1, 4, 64'h0123_4567_89AB_CDEF,
           5, 4, 0, 1'b1, 64'h0123_4567_89AB_CDEF);

    // Drain so the monitor sees the last retirement.
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
